// File: rtl/cmd_grant_scheduler_pkg.sv
// Shared types for the channel CMD-bus grant scheduler: rank index, FSM states
// and a modulo helper for rank index arithmetic.
package cmd_sched_pkg;

    localparam int DEFAULT_NUM_RANK = 4;
    localparam int DEFAULT_MAX_SAME = 4;
    localparam int DEFAULT_RANK_W   = $clog2(DEFAULT_NUM_RANK);

    typedef logic [DEFAULT_RANK_W-1:0] rank_idx_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        TURN  = 2'd1,
        GRANT = 2'd2
    } sched_state_t;

    // Operands are always below the modulus, so one conditional subtract
    // wraps correctly even when NUM_RANK is not a power of two.
    function automatic int wrapAdd(input int base, input int offset, input int modulus);
        int sum;
        sum = base + offset;
        return (sum >= modulus) ? (sum - modulus) : sum;
    endfunction

endpackage

// File: rtl/cmd_grant_scheduler_picker.sv
// Round-robin scan: returns the first requesting index at or after i_start,
// wrapping modulo NUM_RANK, plus a flag saying whether any request was seen.
module rr_priority_picker
    import cmd_sched_pkg::*;
#(
    parameter int NUM_RANK = DEFAULT_NUM_RANK
)
(
    input  logic [NUM_RANK-1:0]         i_req,
    input  logic [$clog2(NUM_RANK)-1:0] i_start,
    output logic [$clog2(NUM_RANK)-1:0] o_idx,
    output logic                        o_found
);

    localparam int RW = $clog2(NUM_RANK);

    logic [RW-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int i = NUM_RANK - 1; i >= 0; i--) begin
            w_cand = RW'(wrapAdd(int'(i_start), i, NUM_RANK));
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_grant_scheduler.sv
// Channel CMD-bus arbiter with owner affinity and rank-turnaround handshake.
// Optional statistics counters are enabled by defining CMD_SCHED_STATS_EN.
module cmd_grant_scheduler
    import cmd_sched_pkg::*;
#(
    parameter int NUM_RANK = DEFAULT_NUM_RANK,
    parameter int MAX_SAME = DEFAULT_MAX_SAME
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RANK-1:0]         cmdReq,
    input  logic                        CMDTurnaroundFree,
    output logic [NUM_RANK-1:0]         cmdGrant,
    output logic                        grantValid,
    output logic [$clog2(NUM_RANK)-1:0] grantRank,
    output logic                        rankTransition
`ifdef CMD_SCHED_STATS_EN
    ,
    output logic [31:0]                 grantCount,
    output logic [31:0]                 transitionCount
`endif
);

    localparam int RW = $clog2(NUM_RANK);
    localparam int CW = $clog2(MAX_SAME + 1);

    function automatic logic [NUM_RANK-1:0] toOnehot(input logic [RW-1:0] idx);
        logic [NUM_RANK-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    sched_state_t        r_state;
    logic [RW-1:0]       r_lastRank;
    logic [RW-1:0]       r_pendRank;
    logic                r_hasOwner;
    logic [CW-1:0]       r_sameCnt;
    logic [NUM_RANK-1:0] r_cmdGrant;
    logic                r_grantValid;
    logic [RW-1:0]       r_grantRank;
    logic                r_rankTransition;

    logic [RW-1:0]       w_scanStart;
    logic [RW-1:0]       w_rrIdx;
    logic                w_rrFound;
    logic [NUM_RANK-1:0] w_ownerMask;
    logic                w_othersReq;
    logic                w_keepOwner;
    logic [RW-1:0]       w_winner;

    assign w_scanStart = RW'(wrapAdd(int'(r_lastRank), 1, NUM_RANK));

    rr_priority_picker #(
        .NUM_RANK (NUM_RANK)
    ) u_picker (
        .i_req   (cmdReq),
        .i_start (w_scanStart),
        .o_idx   (w_rrIdx),
        .o_found (w_rrFound)
    );

    // The owner keeps the bus until it has used its run or nobody else is waiting.
    assign w_ownerMask = toOnehot(r_lastRank);
    assign w_othersReq = |(cmdReq & ~w_ownerMask);
    assign w_keepOwner = r_hasOwner && cmdReq[r_lastRank] &&
                         ((r_sameCnt < CW'(MAX_SAME)) || !w_othersReq);
    assign w_winner    = w_keepOwner ? r_lastRank : w_rrIdx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ARB;
            r_lastRank       <= '0;
            r_pendRank       <= '0;
            r_hasOwner       <= 1'b0;
            r_sameCnt        <= '0;
            r_cmdGrant       <= '0;
            r_grantValid     <= 1'b0;
            r_grantRank      <= '0;
            r_rankTransition <= 1'b0;
        end else begin
            r_cmdGrant       <= '0;
            r_grantValid     <= 1'b0;
            r_grantRank      <= '0;
            r_rankTransition <= 1'b0;
            case (r_state)
                ARB: begin
                    if (w_rrFound) begin
                        r_lastRank <= w_winner;
                        r_hasOwner <= 1'b1;
                        if (!r_hasOwner || (w_winner == r_lastRank)) begin
                            r_state      <= GRANT;
                            r_cmdGrant   <= toOnehot(w_winner);
                            r_grantValid <= 1'b1;
                            r_grantRank  <= w_winner;
                            if (!r_hasOwner) begin
                                r_sameCnt <= '0;
                            end
                        end else begin
                            r_state          <= TURN;
                            r_rankTransition <= 1'b1;
                            r_pendRank       <= w_winner;
                            r_sameCnt        <= '0;
                        end
                    end
                end
                // The free flag may still reflect the previous window on the
                // pulse cycle, so it is only trusted from the second cycle on.
                TURN: begin
                    if (!r_rankTransition && CMDTurnaroundFree) begin
                        if (cmdReq[r_pendRank]) begin
                            r_state      <= GRANT;
                            r_cmdGrant   <= toOnehot(r_pendRank);
                            r_grantValid <= 1'b1;
                            r_grantRank  <= r_pendRank;
                        end else begin
                            r_state <= ARB;
                        end
                    end
                end
                GRANT: begin
                    if (r_sameCnt < CW'(MAX_SAME)) begin
                        r_sameCnt <= r_sameCnt + CW'(1);
                    end
                    r_state <= ARB;
                end
                default: begin
                    r_state <= ARB;
                end
            endcase
        end
    end

    assign cmdGrant       = r_cmdGrant;
    assign grantValid     = r_grantValid;
    assign grantRank      = r_grantRank;
    assign rankTransition = r_rankTransition;

`ifdef CMD_SCHED_STATS_EN
    logic [31:0] r_grantCount;
    logic [31:0] r_transitionCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grantCount      <= '0;
            r_transitionCount <= '0;
        end else begin
            if (r_grantValid) begin
                r_grantCount <= r_grantCount + 32'd1;
            end
            if (r_rankTransition) begin
                r_transitionCount <= r_transitionCount + 32'd1;
            end
        end
    end

    assign grantCount      = r_grantCount;
    assign transitionCount = r_transitionCount;
`endif

endmodule

// File: tb/tb_cmd_grant_scheduler.sv
// Self-checking bench: directed scenarios plus random requesters, compared
// every cycle against a rule-level arbitration model and a tRTRS turnaround model.
module tb_cmd_grant_scheduler;
    import cmd_sched_pkg::*;

    localparam int N     = 4;
    localparam int MS    = 4;
    localparam int TRTRS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cmdReq;
    logic       free;
    logic [3:0] cmdGrant;
    logic       grantValid;
    rank_idx_t  grantRank;
    logic       rankTransition;
`ifdef CMD_SCHED_STATS_EN
    logic [31:0] grantCount;
    logic [31:0] transitionCount;
    logic [31:0] mGrants;
    logic [31:0] mTrans;
`endif

    int checks   = 0;
    int failures = 0;
    int cycleNo  = 0;

    // Reference model: bus owner, run length, and expected outputs for the current cycle.
    int owner;
    bit hasOwner;
    int run;
    bit waitFree;
    bit expValid;
    bit expTrans;
    int expRank;
    int turnCnt;
    bit randTurn;

    cmd_grant_scheduler #(
        .NUM_RANK (N),
        .MAX_SAME (MS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmdReq            (cmdReq),
        .CMDTurnaroundFree (free),
        .cmdGrant          (cmdGrant),
        .grantValid        (grantValid),
        .grantRank         (grantRank),
        .rankTransition    (rankTransition)
`ifdef CMD_SCHED_STATS_EN
        ,
        .grantCount        (grantCount),
        .transitionCount   (transitionCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s @cycle %0d observed=%0h expected=%0h", tag, cycleNo, obs, exp);
        end
    endtask

    function automatic int pickWinner(input logic [3:0] req);
        int others;
        others = 0;
        for (int r = 0; r < N; r++) begin
            if (r != owner && req[r]) others++;
        end
        if (hasOwner && req[owner] && (run < MS || others == 0)) return owner;
        for (int k = 1; k <= N; k++) begin
            if (req[(owner + k) % N]) return (owner + k) % N;
        end
        return owner;
    endfunction

    task automatic resetModel();
        owner    = 0;
        hasOwner = 0;
        run      = 0;
        waitFree = 0;
        expValid = 0;
        expTrans = 0;
        expRank  = 0;
        turnCnt  = 0;
        free     = 1'b1;
`ifdef CMD_SCHED_STATS_EN
        mGrants  = '0;
        mTrans   = '0;
`endif
    endtask

    // Decide what the next cycle must show, given the inputs sampled at the coming edge.
    task automatic advanceModel();
        bit nV;
        bit nT;
        int nR;
        int w;
        nV = 0;
        nT = 0;
        nR = 0;
        if (expValid) begin
            nV = 0;
        end else if (expTrans) begin
            waitFree = 1;
        end else if (waitFree) begin
            if (free) begin
                waitFree = 0;
                if (cmdReq[owner]) begin
                    nV  = 1;
                    nR  = owner;
                    run = (run + 1 > MS) ? MS : run + 1;
                end
            end
        end else if (cmdReq != 4'b0) begin
            w = pickWinner(cmdReq);
            if (!hasOwner || w == owner) begin
                if (!hasOwner) run = 0;
                owner    = w;
                hasOwner = 1;
                nV       = 1;
                nR       = w;
                run      = (run + 1 > MS) ? MS : run + 1;
            end else begin
                owner    = w;
                hasOwner = 1;
                run      = 0;
                nT       = 1;
            end
        end
        expValid = nV;
        expTrans = nT;
        expRank  = nR;
    endtask

    // One cycle: check current outputs, run turnaround model, drive req, predict next.
    task automatic applyStimulus(input logic [3:0] req);
        logic [3:0] expGrant;
        expGrant = expValid ? 4'(1 << expRank) : 4'b0;
        checkOutput("grantValid", 32'(grantValid), 32'(expValid));
        checkOutput("cmdGrant", 32'(cmdGrant), 32'(expGrant));
        checkOutput("rankTransition", 32'(rankTransition), 32'(expTrans));
        if (expValid) checkOutput("grantRank", 32'(grantRank), 32'(expRank));
`ifdef CMD_SCHED_STATS_EN
        checkOutput("grantCount", grantCount, mGrants);
        checkOutput("transitionCount", transitionCount, mTrans);
        mGrants = mGrants + 32'(expValid);
        mTrans  = mTrans + 32'(expTrans);
`endif
        if (expTrans) begin
            free    = 1'b0;
            turnCnt = TRTRS + (randTurn ? int'($urandom_range(0, 2)) : 0);
        end else if (turnCnt > 0) begin
            turnCnt--;
            if (turnCnt == 0) free = 1'b1;
        end
        cmdReq = req;
        advanceModel();
        cycleNo++;
        @(negedge clk);
    endtask

    task automatic doReset();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_grantValid", 32'(grantValid), 32'd0);
        checkOutput("rst_cmdGrant", 32'(cmdGrant), 32'd0);
        checkOutput("rst_grantRank", 32'(grantRank), 32'd0);
        checkOutput("rst_rankTransition", 32'(rankTransition), 32'd0);
`ifdef CMD_SCHED_STATS_EN
        checkOutput("rst_grantCount", grantCount, 32'd0);
        checkOutput("rst_transitionCount", transitionCount, 32'd0);
`endif
        cmdReq = 4'b0;
        resetModel();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Hold one request pattern until the named rank has been granted, then drop it.
    task automatic requestUntilGrant(input logic [3:0] req, input int rank, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(seen ? 4'b0 : req);
            if (expValid && expRank == rank) seen = 1;
        end
    endtask

    initial begin
        bit       found;
        logic [3:0] req;
        rst      = 1'b1;
        cmdReq   = 4'b0;
        randTurn = 0;
        resetModel();
        #1;
        doReset();

        // Single requester after reset: ARB then GRANT, repeating every 2 cycles.
        for (int i = 0; i < 8; i++) applyStimulus(4'b0001);

        // Owner rank0 hands over to rank2 through a turnaround window.
        requestUntilGrant(4'b0100, 2, 10);

`ifdef CMD_SCHED_STATS_EN
        force dut.r_grantCount = 32'hFFFF_FFFF;
        force dut.r_transitionCount = 32'hFFFF_FFFF;
        #1;
        release dut.r_grantCount;
        release dut.r_transitionCount;
        mGrants = 32'hFFFF_FFFF;
        mTrans  = 32'hFFFF_FFFF;
`endif

        // Owner rank1 with 1011 held: run limit, then rank3, then rank0.
        requestUntilGrant(4'b0010, 1, 8);
        for (int i = 0; i < 30; i++) applyStimulus(4'b1011);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000);

        // Make rank0 the owner, then withdraw a rank1 request during its turnaround.
        requestUntilGrant(4'b0001, 0, 10);
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            applyStimulus(4'b0010);
            if (expTrans) found = 1;
        end
        checkOutput("withdraw_reached_turn", 32'(rankTransition), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(4'b0000);
        requestUntilGrant(4'b0010, 1, 6);

        // Reset in the middle of a turnaround; first grant afterwards has no transition.
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            applyStimulus(4'b0100);
            if (expTrans) found = 1;
        end
        checkOutput("reset_reached_turn", 32'(rankTransition), 32'd1);
        doReset();
        requestUntilGrant(4'b1000, 3, 6);

        // Random requesters that hold until granted and may drop after a grant.
        randTurn = 1;
        for (int c = 0; c < 600; c++) begin
            req = cmdReq;
            for (int r = 0; r < N; r++) begin
                if (expValid && expRank == r) begin
                    if ($urandom_range(0, 1) == 1) req[r] = 1'b0;
                end else if (!req[r] && $urandom_range(0, 3) == 0) begin
                    req[r] = 1'b1;
                end
            end
            applyStimulus(req);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
